// File: rtl/mem_stage_ctrl_if.sv
// Bundle of the EX/MEM-side inputs, the data-memory port and the MEM/WB-side
// results of the memory-stage controller.
interface mem_stage_ctrl_if #(
   parameter int ADDR_WIDTH = 11
);
   logic                  in_valid;
   logic [2:0]            op;
   logic [31:0]           addr;
   logic [15:0]           wdata;
   logic [31:0]           pc_ret;
   logic                  stall;
   logic [31:0]           mem_address;
   logic [15:0]           mem_write_data;
   logic                  mem_read;
   logic                  mem_write;
   logic                  mem_cs;
   logic [15:0]           mem_read_data;
   logic [31:0]           result_data;
   logic                  result_valid;
   logic [ADDR_WIDTH-1:0] sp;
   logic                  exc_overflow;
   logic                  exc_underflow;

   modport master (
      output in_valid, op, addr, wdata, pc_ret, mem_read_data,
      input  stall, mem_address, mem_write_data, mem_read, mem_write, mem_cs,
             result_data, result_valid, sp, exc_overflow, exc_underflow
   );

   modport slave (
      input  in_valid, op, addr, wdata, pc_ret, mem_read_data,
      output stall, mem_address, mem_write_data, mem_read, mem_write, mem_cs,
             result_data, result_valid, sp, exc_overflow, exc_underflow
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: decodes memory ops, drives the data memory, owns
// the stack pointer and splits 32-bit CALL/RET frames into two word accesses.
module mem_stage_ctrl #(
   parameter int                    ADDR_WIDTH  = 11,
   parameter logic [ADDR_WIDTH-1:0] SP_RESET    = 11'h7FF,
   parameter logic [ADDR_WIDTH-1:0] STACK_LIMIT = 11'h400
) (
   input logic            clk,
   input logic            rst,
   mem_stage_ctrl_if.slave bus
);

   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_STORE = 3'd2;
   localparam logic [2:0] OP_PUSH  = 3'd3;
   localparam logic [2:0] OP_POP   = 3'd4;
   localparam logic [2:0] OP_CALL  = 3'd5;
   localparam logic [2:0] OP_RET   = 3'd6;

   localparam logic [ADDR_WIDTH-1:0] CALL_LIMIT = STACK_LIMIT + 1'b1;
   localparam logic [ADDR_WIDTH-1:0] RET_LIMIT  = SP_RESET - 2'd2;

   typedef enum logic {IDLE, SECOND} state_t;

   state_t                state, stateNext;
   logic [ADDR_WIDTH-1:0] spReg, spNext, spUp, spDown;
   logic                  secondIsRet, secondIsRetNext;
   logic [15:0]           hold, holdNext;
   logic [31:0]           resultReg, resultNext;
   logic                  validReg, validNext;
   logic                  ovfReg, ovfNext;
   logic                  unfReg, unfNext;
   logic                  rd, wr, stallC;
   logic [ADDR_WIDTH-1:0] memAddr;
   logic [15:0]           memData;
   logic                  unusedAddrBits;

   // Address bits above the memory width alias onto the same words.
   assign unusedAddrBits = ^bus.addr[31:ADDR_WIDTH];

   assign spUp   = spReg + 1'b1;
   assign spDown = spReg - 1'b1;

   // State, stack pointer and the registered MEM/WB outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         spReg       <= SP_RESET;
         secondIsRet <= 1'b0;
         hold        <= '0;
         resultReg   <= '0;
         validReg    <= 1'b0;
         ovfReg      <= 1'b0;
         unfReg      <= 1'b0;
      end else begin
         state       <= stateNext;
         spReg       <= spNext;
         secondIsRet <= secondIsRetNext;
         hold        <= holdNext;
         resultReg   <= resultNext;
         validReg    <= validNext;
         ovfReg      <= ovfNext;
         unfReg      <= unfNext;
      end
   end

   // Decode and sequencing; a reset cycle issues no memory access so an
   // interrupted CALL stops after its first word.
   always_comb begin
      stateNext       = state;
      spNext          = spReg;
      secondIsRetNext = secondIsRet;
      holdNext        = hold;
      resultNext      = resultReg;
      validNext       = 1'b0;
      ovfNext         = 1'b0;
      unfNext         = 1'b0;
      rd              = 1'b0;
      wr              = 1'b0;
      stallC          = 1'b0;
      memAddr         = '0;
      memData         = '0;
      if (!rst) begin
         if (state == SECOND) begin
            stateNext = IDLE;
            if (secondIsRet) begin
               rd         = 1'b1;
               memAddr    = spUp;
               resultNext = {bus.mem_read_data, hold};
               validNext  = 1'b1;
               spNext     = spUp;
            end else begin
               wr      = 1'b1;
               memAddr = spReg;
               memData = bus.pc_ret[15:0];
               spNext  = spDown;
            end
         end else if (bus.in_valid) begin
            case (bus.op)
               OP_LOAD: begin
                  rd         = 1'b1;
                  memAddr    = bus.addr[ADDR_WIDTH-1:0];
                  resultNext = {16'h0, bus.mem_read_data};
                  validNext  = 1'b1;
               end
               OP_STORE: begin
                  wr      = 1'b1;
                  memAddr = bus.addr[ADDR_WIDTH-1:0];
                  memData = bus.wdata;
               end
               OP_PUSH: begin
                  if (spReg >= STACK_LIMIT) begin
                     wr      = 1'b1;
                     memAddr = spReg;
                     memData = bus.wdata;
                     spNext  = spDown;
                  end else begin
                     ovfNext = 1'b1;
                  end
               end
               OP_POP: begin
                  if (spReg < SP_RESET) begin
                     rd         = 1'b1;
                     memAddr    = spUp;
                     resultNext = {16'h0, bus.mem_read_data};
                     validNext  = 1'b1;
                     spNext     = spUp;
                  end else begin
                     unfNext = 1'b1;
                  end
               end
               OP_CALL: begin
                  if (spReg >= CALL_LIMIT) begin
                     stallC          = 1'b1;
                     wr              = 1'b1;
                     memAddr         = spReg;
                     memData         = bus.pc_ret[31:16];
                     spNext          = spDown;
                     secondIsRetNext = 1'b0;
                     stateNext       = SECOND;
                  end else begin
                     ovfNext = 1'b1;
                  end
               end
               OP_RET: begin
                  if (spReg <= RET_LIMIT) begin
                     stallC          = 1'b1;
                     rd              = 1'b1;
                     memAddr         = spUp;
                     holdNext        = bus.mem_read_data;
                     spNext          = spUp;
                     secondIsRetNext = 1'b1;
                     stateNext       = SECOND;
                  end else begin
                     unfNext = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.stall          = stallC;
   assign bus.mem_read       = rd;
   assign bus.mem_write      = wr;
   assign bus.mem_cs         = rd | wr;
   assign bus.mem_address    = {{(32-ADDR_WIDTH){1'b0}}, memAddr};
   assign bus.mem_write_data = memData;
   assign bus.result_data    = resultReg;
   assign bus.result_valid   = validReg;
   assign bus.sp             = spReg;
   assign bus.exc_overflow   = ovfReg;
   assign bus.exc_underflow  = unfReg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed stack/CALL/RET boundary
// steps followed by random ops, compared against a word-level stack model.
module tb_mem_stage_ctrl;

   logic clk;
   logic rst;
   logic [15:0] ram [0:2047];
   logic [15:0] refMem [0:2047];
   int refSp;
   logic [31:0] refResult;
   int total;
   int bad;

   mem_stage_ctrl_if #(.ADDR_WIDTH(11)) bus ();

   mem_stage_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: asynchronous read, write on the clock edge.
   assign bus.mem_read_data = ram[bus.mem_address[10:0]];
   always @(posedge clk) begin
      if (bus.mem_write) ram[bus.mem_address[10:0]] <= bus.mem_write_data;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkRegs();
      checkOutput("sp", 32'(bus.sp), 32'(refSp));
      checkOutput("result_data", bus.result_data, refResult);
   endtask

   // One operation: the model predicts every access cycle and the edge after.
   task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [31:0] a,
                                input logic [15:0] d, input logic [31:0] pc);
      logic [1:0]  eStall, eRd, eWr;
      logic [10:0] eAddr [2];
      logic [15:0] eData [2];
      logic        eValid, eOvf, eUnf;
      int          cycles;
      cycles = 1;
      eStall = '0; eRd = '0; eWr = '0;
      eAddr[0] = '0; eAddr[1] = '0; eData[0] = '0; eData[1] = '0;
      eValid = 1'b0; eOvf = 1'b0; eUnf = 1'b0;
      bus.in_valid = v; bus.op = o; bus.addr = a; bus.wdata = d; bus.pc_ret = pc;
      if (v) begin
         case (o)
            3'd1: begin
               eRd[0] = 1'b1; eAddr[0] = a[10:0];
               refResult = {16'h0, refMem[a[10:0]]}; eValid = 1'b1;
            end
            3'd2: begin
               eWr[0] = 1'b1; eAddr[0] = a[10:0]; eData[0] = d;
               refMem[a[10:0]] = d;
            end
            3'd3: begin
               if (refSp >= 'h400) begin
                  eWr[0] = 1'b1; eAddr[0] = 11'(refSp); eData[0] = d;
                  refMem[refSp] = d; refSp--;
               end else eOvf = 1'b1;
            end
            3'd4: begin
               if (refSp < 'h7FF) begin
                  refSp++;
                  eRd[0] = 1'b1; eAddr[0] = 11'(refSp);
                  refResult = {16'h0, refMem[refSp]}; eValid = 1'b1;
               end else eUnf = 1'b1;
            end
            3'd5: begin
               if (refSp >= 'h401) begin
                  cycles = 2; eStall[0] = 1'b1; eWr = 2'b11;
                  eAddr[0] = 11'(refSp);     eData[0] = pc[31:16];
                  eAddr[1] = 11'(refSp - 1); eData[1] = pc[15:0];
                  refMem[refSp] = pc[31:16]; refMem[refSp - 1] = pc[15:0];
                  refSp -= 2;
               end else eOvf = 1'b1;
            end
            3'd6: begin
               if (refSp <= 'h7FD) begin
                  cycles = 2; eStall[0] = 1'b1; eRd = 2'b11;
                  eAddr[0] = 11'(refSp + 1); eAddr[1] = 11'(refSp + 2);
                  refResult = {refMem[refSp + 2], refMem[refSp + 1]};
                  eValid = 1'b1; refSp += 2;
               end else eUnf = 1'b1;
            end
            default: ;
         endcase
      end
      for (int c = 0; c < cycles; c++) begin
         #3;
         checkOutput("stall", 32'(bus.stall), 32'(eStall[c]));
         checkOutput("mem_read", 32'(bus.mem_read), 32'(eRd[c]));
         checkOutput("mem_write", 32'(bus.mem_write), 32'(eWr[c]));
         checkOutput("mem_cs", 32'(bus.mem_cs), 32'(eRd[c] | eWr[c]));
         checkOutput("mem_address", bus.mem_address, 32'(eAddr[c]));
         checkOutput("mem_write_data", 32'(bus.mem_write_data), 32'(eData[c]));
         @(posedge clk);
         #1;
      end
      checkOutput("result_valid", 32'(bus.result_valid), 32'(eValid));
      checkOutput("exc_overflow", 32'(bus.exc_overflow), 32'(eOvf));
      checkOutput("exc_underflow", 32'(bus.exc_underflow), 32'(eUnf));
      checkRegs();
   endtask

   task automatic applyReset();
      bus.in_valid = 1'b0; bus.op = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      refSp = 'h7FF;
      refResult = '0;
      checkRegs();
      checkOutput("reset_valid", 32'(bus.result_valid), 32'd0);
      checkOutput("reset_exc", 32'({bus.exc_overflow, bus.exc_underflow}), 32'd0);
      checkOutput("reset_stall", 32'(bus.stall), 32'd0);
      checkOutput("reset_cs", 32'(bus.mem_cs), 32'd0);
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.op = '0; bus.addr = '0; bus.wdata = '0; bus.pc_ret = '0;
      @(posedge clk);
      #1;
      applyReset();

      // STORE then LOAD through an aliased address, and an invalid LOAD.
      applyStimulus(1, 3'd2, 32'h10, 16'hBEEF, 0);
      applyStimulus(1, 3'd1, 32'hFFFF_F810, 0, 0);
      checkOutput("load_beef", bus.result_data, 32'h0000_BEEF);
      applyStimulus(0, 3'd1, 32'h10, 0, 0);
      applyStimulus(1, 3'd7, 32'h10, 16'h5555, 32'h1);

      // PUSH/POP and a full CALL/RET frame.
      applyStimulus(1, 3'd3, 0, 16'h1234, 0);
      applyStimulus(1, 3'd4, 0, 0, 0);
      checkOutput("pop_1234", bus.result_data, 32'h0000_1234);
      applyStimulus(1, 3'd5, 0, 0, 32'hCAFE_0042);
      checkOutput("call_hi", 32'(ram[11'h7FF]), 32'h0000_CAFE);
      checkOutput("call_lo", 32'(ram[11'h7FE]), 32'h0000_0042);
      applyStimulus(1, 3'd6, 0, 0, 0);
      checkOutput("ret_value", bus.result_data, 32'hCAFE_0042);

      // Underflow boundaries.
      applyStimulus(1, 3'd4, 0, 0, 0);
      applyStimulus(1, 3'd6, 0, 0, 0);
      applyStimulus(1, 3'd3, 0, 16'hA5A5, 0);
      applyStimulus(1, 3'd6, 0, 0, 0);
      applyStimulus(1, 3'd4, 0, 0, 0);

      // Overflow boundaries at the stack limit.
      while (refSp > 'h3FF) applyStimulus(1, 3'd3, 0, 16'($urandom), 0);
      applyStimulus(1, 3'd3, 0, 16'hDEAD, 0);
      applyStimulus(1, 3'd4, 0, 0, 0);
      applyStimulus(1, 3'd5, 0, 0, 32'h1357_2468);
      applyStimulus(1, 3'd4, 0, 0, 0);
      applyStimulus(1, 3'd5, 0, 0, 32'h1357_2468);
      applyStimulus(1, 3'd6, 0, 0, 0);
      checkOutput("ret_limit", bus.result_data, 32'h1357_2468);
      applyReset();

      // Reset landing on the second cycle of a CALL.
      bus.in_valid = 1'b1; bus.op = 3'd5; bus.pc_ret = 32'h1111_2222;
      #3;
      checkOutput("abort_stall", 32'(bus.stall), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0; bus.op = '0;
      refSp = 'h7FF; refResult = '0;
      refMem[11'h7FF] = 16'h1111;
      checkRegs();
      checkOutput("abort_outputs", 32'({bus.stall, bus.mem_cs, bus.result_valid,
                  bus.exc_overflow, bus.exc_underflow}), 32'd0);
      applyStimulus(1, 3'd3, 0, 16'h7777, 0);
      applyStimulus(1, 3'd4, 0, 0, 0);

      // Random ops; LOAD/STORE stay in a pre-written low region.
      for (int i = 0; i < 16; i++) applyStimulus(1, 3'd2, 32'(i), 16'($urandom), 0);
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
                       ($urandom & 32'hFFFF_F800) | 32'($urandom_range(0, 15)),
                       16'($urandom), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller of the five-stage pipeline. It sits between the EX/MEM pipeline register and the 2K x 16-bit data memory.
- Decodes the memory operation and drives the data-memory address, data, read, write and chip-select lines.
- Owns the stack pointer. Sequences 32-bit CALL/RET return-address transfers as two 16-bit accesses, stalling upstream for one cycle.
- Produces a registered result and stack fault flags for the MEM/WB register.

Parameters:
- ADDR_WIDTH, 11, data-memory word-address width; SP width.
- SP_RESET, 11'h7FF, stack top (empty-stack SP value); highest stack word.
- STACK_LIMIT, 11'h400, lowest legal stack word address.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  EX/MEM entry valid.
- op  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET; 7 treated as NOP.
- addr  in  32  LOAD/STORE address; bits [ADDR_WIDTH-1:0] used.
- wdata  in  16  STORE/PUSH data.
- pc_ret  in  32  return address for CALL.
- stall  out  1  combinational; upstream must hold all inputs while high.
- mem_address  out  32  to data memory; zero-extended word address.
- mem_write_data  out  16  to data memory.
- mem_read  out  1  to data memory.
- mem_write  out  1  to data memory.
- mem_cs  out  1  to data memory.
- mem_read_data  in  16  from data memory; valid combinationally in the same cycle as mem_read.
- result_data  out  32  registered load/pop/ret result.
- result_valid  out  1  registered one-cycle pulse.
- sp  out  ADDR_WIDTH  current stack pointer.
- exc_overflow  out  1  registered one-cycle pulse on push-type fault.
- exc_underflow  out  1  registered one-cycle pulse on pop-type fault.

Behaviour:

Reset:
- state=IDLE, sp=SP_RESET.
- result_data=0, result_valid=0, exc_overflow=0, exc_underflow=0, low-word hold register=0.
- Reset in SECOND aborts the operation. A half-written CALL frame is not undone.

Memory interface:
- mem_read and mem_write are never both high. mem_cs=mem_read|mem_write.
- All mem_* outputs are 0 when idle, for NOP, for faults, or when in_valid=0.

Registered outputs:
- result_valid, exc_overflow and exc_underflow default to 0 each cycle; result_data holds its value.

Stack convention:
- Empty-descending stack: PUSH writes at sp, then sp-1. POP sets sp+1, then reads at the new sp.
- Fault legality checks (evaluated in IDLE only):
  - PUSH legal if sp>=STACK_LIMIT; CALL legal if sp>=STACK_LIMIT+1; else exc_overflow.
  - POP legal if sp<SP_RESET; RET legal if sp<=SP_RESET-2; else exc_underflow.
- Faulting op: no memory access, sp unchanged, no stall, no result_valid.

IDLE state, in_valid=1:
- LOAD: mem_read, address=addr. Next edge: result_data={16'h0, mem_read_data}, result_valid=1. Latency 1, no stall.
- STORE: mem_write, address=addr, data=wdata. Memory writes at the same edge. No result.
- PUSH: mem_write at sp with wdata. Edge: sp<=sp-1.
- POP: mem_read at sp+1. Edge: result_data={16'h0, mem_read_data}, result_valid=1, sp<=sp+1.
- CALL, first cycle:
  - stall=1; mem_write at sp with pc_ret[31:16].
  - Edge: sp<=sp-1, state<=SECOND.
- RET, first cycle:
  - stall=1; mem_read at sp+1.
  - Edge: hold<=mem_read_data (low word), sp<=sp+1, state<=SECOND.

SECOND state (stall=0):
- CALL: mem_write at sp with pc_ret[15:0]. Edge: sp<=sp-1, state<=IDLE.
- RET: mem_read at sp+1. Edge: result_data={mem_read_data, hold}, result_valid=1, sp<=sp+1, state<=IDLE.
- The op used in SECOND is the latched op of the first cycle. Inputs are held by upstream, but the controller does not depend on op in SECOND.

Arithmetic and widths:
- sp arithmetic is ADDR_WIDTH-bit; the fault checks guarantee no wrap.
- addr bits above ADDR_WIDTH are ignored (aliasing).

Test Plan:
- Reset, then STORE addr=0x10 wdata=0xBEEF, then LOAD addr=0x10 -> STORE cycle has mem_write=1; result_valid=1 one cycle after LOAD with result_data=0x0000BEEF.
- From reset, PUSH 0x1234 then POP -> PUSH writes addr 0x7FF, sp 0x7FF->0x7FE->0x7FF; POP reads 0x7FF, result_data=0x00001234.
- CALL pc_ret=0xCAFE0042 then RET:
  - CALL: stall=1 for one cycle; mem[0x7FF]=0xCAFE, mem[0x7FE]=0x0042; sp=0x7FD.
  - RET: stall=1 for one cycle; result_data=0xCAFE0042; sp=0x7FF.
- POP and RET with sp=0x7FF, and RET with sp=0x7FE -> exc_underflow pulses once each; no mem_cs; sp unchanged; stall=0.
- Push until sp=0x3FF, then PUSH, and CALL with sp=0x400 -> exc_overflow each; no write; sp unchanged.
- rst asserted during the CALL SECOND cycle -> next cycle state IDLE, sp=0x7FF, all outputs 0, stall=0.
